// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types, widths and the read-accept helper for the
//               FIFO burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 9;   // holds 1..256

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A read may be issued only when every term holds, so each request
    // pops exactly one byte and the returning byte always has a slot.
    function automatic logic read_accept(
        input state_t           st,
        input logic             fifo_ready,
        input logic             fifo_empty,
        input logic [LEN_W-1:0] remaining,
        input logic             credit_ok
    );
        return (st == BURST) && fifo_ready && !fifo_empty &&
               (remaining != '0) && credit_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : DEPTH-entry FIFO-ordered output buffer for the burst reader.
//               Absorbs bytes returning from the FIFO read latency while the
//               consumer stalls.
// Ports       : clk, resetn     - clock, async active-low reset
//               push, wdata     - write one byte
//               pop             - release the head entry
//               occ             - current occupancy (0..DEPTH)
//               head            - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [DATA_W-1:0]          head
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Credit logic upstream must make these unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (occ == OCC_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(pop && (occ == '0)));

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Read-side master for an 8-bit request/ready FIFO. On start
//               it pops burst_len bytes (0 = 256) and streams them over a
//               valid/ready interface with a last marker, sustaining one byte
//               per cycle by hiding the FIFO read latency behind a
//               credit-managed buffer.
// Ports       : clk, resetn            - clock, async active-low reset
//               start, burst_len       - burst request (ignored while busy)
//               i_rreq                 - read request to FIFO
//               o_rready, fifo_isempty - FIFO read-port status
//               rdata                  - FIFO data, one cycle after request
//               m_valid/m_data/m_last  - output stream
//               m_ready                - consumer ready
//               busy, done             - burst status, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        burst_len,
    output logic              i_rreq,
    input  logic              o_rready,
    input  logic              fifo_isempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] beats_out;
    logic [LEN_W-1:0] len_load;
    logic             inflight;
    logic             pop;
    logic             credit_ok;
    logic [OCC_W-1:0] occ;

    assign len_load = (burst_len == 8'd0) ? LEN_W'(256) : {1'b0, burst_len};
    assign pop      = m_valid && m_ready;

    // A slot freed by this cycle's pop may be reused by this cycle's read,
    // which is what keeps one byte per cycle with only DEPTH entries.
    assign credit_ok = (32'(occ) + 32'(inflight)) < (32'(DEPTH) + 32'(pop));

    assign i_rreq = read_accept(state, o_rready, fifo_isempty, remaining, credit_ok);

    fifo_rd_skid #(
        .DEPTH (DEPTH)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight),
        .wdata  (rdata),
        .pop    (pop),
        .occ    (occ),
        .head   (m_data)
    );

    assign m_valid = (occ != '0);
    assign m_last  = m_valid && (beats_out == LEN_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                busy = 1'b1;
                if (i_rreq && (remaining == LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && (beats_out == LEN_W'(1))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // inflight is cleared by reset, so a byte requested just before reset
    // is never written into the buffer when it returns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remaining <= '0;
            beats_out <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= i_rreq;
            done     <= (state == DRAIN) && pop && (beats_out == LEN_W'(1));
            if ((state == IDLE) && start) begin
                remaining <= len_load;
                beats_out <= len_load;
            end else begin
                if (i_rreq) begin
                    remaining <= remaining - LEN_W'(1);
                end
                if (pop) begin
                    beats_out <= beats_out - LEN_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader with a behavioural
//               FIFO (byte at index i holds 0x10+i) and an expected-beat
//               scoreboard filled when each burst is started.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] burst_len;
    logic       i_rreq;
    logic       o_rready;
    logic       fifo_isempty;
    logic [7:0] rdata = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       busy;
    logic       done;

    fifo_burst_reader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .burst_len    (burst_len),
        .i_rreq       (i_rreq),
        .o_rready     (o_rready),
        .fifo_isempty (fifo_isempty),
        .rdata        (rdata),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: one-cycle read latency, not affected by DUT reset.
    logic [7:0] fmem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_isempty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (i_rreq && o_rready && (wr_ptr != rd_ptr)) begin
            rdata  <= fmem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q [$];
    int   exp_rd = 0;
    int   b_occ = 0;
    int   b_inf = 0;
    logic hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    int   beats, rreqs, dones;
    int   first_rreq, first_valid, last_seen, last_acc_cyc;
    int   c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr] = 8'(wr_ptr + 16);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic push_burst(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(k == n - 1), 8'(exp_rd + k + 16)});
        end
        exp_rd = exp_rd + n;
    endtask

    task automatic clear_stats();
        beats = 0; rreqs = 0; dones = 0;
        first_rreq = -1; first_valid = -1; last_seen = -1; last_acc_cyc = -1;
    endtask

    // Sample just after inputs settle, then advance past the next edge.
    task automatic tick();
        logic p;
        logic [8:0] e;
        #1;
        p = m_valid && m_ready;
        if (hold_v) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_d);
        end
        if (p) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e[7:0]);
                check("beat_last", m_last, e[8]);
            end
            beats++;
            if (m_last) last_acc_cyc = cyc + 1;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_last && last_seen < 0) last_seen = cyc;
        if (i_rreq) begin
            rreqs++;
            if (first_rreq < 0) first_rreq = cyc;
            check("rreq_when_empty", fifo_isempty, 0);
            check("rreq_credit", (b_occ + b_inf - int'(p)) < DEPTH, 1);
        end
        check("valid_vs_model", m_valid, b_occ != 0);
        if (done) begin
            dones++;
            check("done_cycle", cyc, last_acc_cyc);
            check("busy_at_done", busy, 0);
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        b_occ  = b_occ + b_inf - int'(p);
        b_inf  = int'(i_rreq && o_rready && !fifo_isempty);
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input int n);
        start = 1'b1;
        burst_len = len;
        push_burst(n);
        tick();
        c0 = cyc;
        start = 1'b0;
        burst_len = 8'hAA;
    endtask

    task automatic run_until_done(input int max_cyc);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("burst_timeout", dones != d0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rreq"},  i_rreq, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"},  m_data, 0);
        check({tag, "_last"},  m_last, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int n;
        int avail;
        resetn = 1'b0; start = 1'b0; burst_len = 8'h00;
        o_rready = 1'b1; m_ready = 1'b1;
        clear_stats();
        tick();
        tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();

        // 1: four preloaded bytes, consumer always ready
        write_bytes(4);
        clear_stats();
        do_start(8'd4, 4);
        check("busy_after_start", busy, 1);
        run_until_done(20);
        check("b1_first_rreq", first_rreq, c0);
        check("b1_first_valid", first_valid, c0 + 2);
        check("b1_last_cycle", last_seen, c0 + 5);
        check("b1_rreqs", rreqs, 4);
        check("b1_beats", beats, 4);
        check("b1_dones", dones, 1);
        check("b1_scoreboard_empty", exp_q.size(), 0);

        // 2: burst_len 0 means 256 bytes
        write_bytes(300);
        clear_stats();
        do_start(8'd0, 256);
        run_until_done(400);
        check("b2_beats", beats, 256);
        check("b2_fifo_left", wr_ptr - rd_ptr, 44);
        check("b2_scoreboard_empty", exp_q.size(), 0);

        // 3: consumer ready pattern 1,0,0,1
        pat = 4'b1001;
        clear_stats();
        do_start(8'd8, 8);
        n = 0;
        while (dones == 0 && n < 200) begin
            m_ready = pat[n % 4];
            tick();
            n++;
        end
        check("b3_finished", dones, 1);
        check("b3_beats", beats, 8);
        check("b3_scoreboard_empty", exp_q.size(), 0);
        m_ready = 1'b1;

        // 4: FIFO runs dry mid-burst, then refilled
        avail = wr_ptr - rd_ptr;
        clear_stats();
        do_start(8'(avail + 3), avail + 3);
        n = 0;
        while (!fifo_isempty && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("b4_stall_rreq", i_rreq, 0);
            check("b4_stall_busy", busy, 1);
            tick();
        end
        write_bytes(3);
        run_until_done(30);
        check("b4_beats", beats, avail + 3);

        // 5: second start during a burst is ignored
        write_bytes(6);
        clear_stats();
        do_start(8'd6, 6);
        tick();
        start = 1'b1; burst_len = 8'd1;
        tick();
        start = 1'b0;
        run_until_done(30);
        for (int i = 0; i < 5; i++) tick();
        check("b5_beats", beats, 6);
        check("b5_dones", dones, 1);
        check("b5_scoreboard_empty", exp_q.size(), 0);

        // 6: reset with one byte buffered and one in flight
        write_bytes(6);
        m_ready = 1'b0;
        clear_stats();
        do_start(8'd5, 5);
        tick();
        tick();
        check("b6_prereset_valid", m_valid, 1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        b_occ = 0; b_inf = 0; hold_v = 1'b0;
        exp_rd = rd_ptr;
        m_ready = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        clear_stats();
        do_start(8'd2, 2);
        run_until_done(20);
        check("b6_beats", beats, 2);
        check("b6_fifo_left", wr_ptr - rd_ptr, 2);
        check("b6_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
